// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: format codes, frame geometry
// and the LRCK level of each slot for each output format.
package i2s_pkg;

  localparam int FMT_I2S  = 0;
  localparam int FMT_LJ16 = 1;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;
  localparam int SAMPLE_BITS = 16;
  localparam int BIT_W       = $clog2(FRAME_BITS);

  localparam logic LRCK_LEFT_I2S   = 1'b0;
  localparam logic LRCK_RIGHT_I2S  = 1'b1;
  localparam logic LRCK_LEFT_LJ16  = 1'b1;
  localparam logic LRCK_RIGHT_LJ16 = 1'b0;

  function automatic logic lrck_level(input int fmt, input logic right_slot);
    if (fmt == FMT_I2S) return right_slot ? LRCK_RIGHT_I2S : LRCK_LEFT_I2S;
    return right_slot ? LRCK_RIGHT_LJ16 : LRCK_LEFT_LJ16;
  endfunction

  // I2S delays the MSB by one BCK after the LRCK edge; left-justified does not.
  function automatic int data_offset(input int fmt);
    return (fmt == FMT_I2S) ? 1 : 0;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_timer.sv
// Frame timer: mck divider to BCK and 64-bit frame counter. Exposes the
// next-state bit index, next BCK level and the frame-load strobe.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int MCK_PER_BCK = 4
) (
  input  logic             mck,
  input  logic             reset_n,
  output logic [BIT_W-1:0] bit_next,
  output logic             bck_next,
  output logic             frame_start
);

  localparam int DIV_W = $clog2(MCK_PER_BCK);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(MCK_PER_BCK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCK_PER_BCK / 2);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  // Reset parks both counters at their last value so the first edge after
  // release wraps into bit 0 and is itself a frame load.
  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_MAX;
      bit_q <= BIT_MAX;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end

  always_comb begin
    div_d       = div_q + 1'b1;
    bit_d       = bit_q;
    frame_start = 1'b0;
    if (div_q == DIV_MAX) begin
      div_d       = '0;
      bit_d       = bit_q + 1'b1;
      frame_start = (bit_q == BIT_MAX);
    end
    bit_next = bit_d;
    bck_next = (div_d >= DIV_HALF);
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S / 16-bit left-justified transmitter: one-deep holding register behind a
// valid/ready port, per-frame sample registers and registered BCK/LRCK/DATA.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int MCK_PER_BCK = 4,
  parameter int FORMAT      = 0
) (
  input  logic                   mck,
  input  logic                   reset_n,
  input  logic [SAMPLE_BITS-1:0] s_left,
  input  logic [SAMPLE_BITS-1:0] s_right,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   bck,
  output logic                   lrck,
  output logic                   data,
  output logic                   underrun
);

  localparam logic [4:0] OFFSET = 5'(data_offset(FORMAT));
  localparam logic       LRCK_RESET = lrck_level(FORMAT, 1'b1);

  logic [BIT_W-1:0] bit_next;
  logic             bck_next;
  logic             frame_start;

  i2s_frame_timer #(
    .MCK_PER_BCK(MCK_PER_BCK)
  ) u_timer (
    .mck        (mck),
    .reset_n    (reset_n),
    .bit_next   (bit_next),
    .bck_next   (bck_next),
    .frame_start(frame_start)
  );

  logic                   hold_full_q, hold_full_d;
  logic [SAMPLE_BITS-1:0] hold_left_q, hold_left_d;
  logic [SAMPLE_BITS-1:0] hold_right_q, hold_right_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [SAMPLE_BITS-1:0] right_q, right_d;
  logic                   bck_q, bck_d;
  logic                   lrck_q, lrck_d;
  logic                   data_q, data_d;
  logic                   underrun_q, underrun_d;

  logic                   accept;
  logic                   right_slot;
  logic [4:0]             slot_pos;
  logic [4:0]             rel_pos;
  logic [3:0]             word_idx;
  logic [SAMPLE_BITS-1:0] word;

  assign s_ready = !hold_full_q;

  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      left_q       <= '0;
      right_q      <= '0;
      bck_q        <= 1'b1;
      lrck_q       <= LRCK_RESET;
      data_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      left_q       <= left_d;
      right_q      <= right_d;
      bck_q        <= bck_d;
      lrck_q       <= lrck_d;
      data_q       <= data_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    accept       = s_valid && !hold_full_q;
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    left_d       = left_q;
    right_d      = right_q;
    underrun_d   = 1'b0;

    if (frame_start) begin
      if (hold_full_q) begin
        left_d      = hold_left_q;
        right_d     = hold_right_q;
        hold_full_d = 1'b0;
      end else begin
        left_d     = '0;
        right_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // A pair accepted on an empty load edge misses this frame and waits in holding.
    if (accept) begin
      hold_left_d  = s_left;
      hold_right_d = s_right;
      hold_full_d  = 1'b1;
    end

    // Outputs follow the post-edge bit index so data lines up with the BCK fall.
    right_slot = bit_next[BIT_W-1];
    slot_pos   = bit_next[4:0];
    rel_pos    = slot_pos - OFFSET;
    word_idx   = 4'hF - rel_pos[3:0];
    word       = right_slot ? right_d : left_d;
    data_d     = 1'b0;
    if ((slot_pos >= OFFSET) && (rel_pos < 5'(SAMPLE_BITS))) begin
      data_d = word[word_idx];
    end

    bck_d  = bck_next;
    lrck_d = lrck_level(FORMAT, right_slot);
  end

  assign bck      = bck_q;
  assign lrck     = lrck_q;
  assign data     = data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: I2S and 16LJ instances share one stimulus
// stream and are checked every cycle against a cycle-count/queue model.
module tb_i2s_tx_serializer;

  localparam int M     = 4;
  localparam int FRAME = 64 * M;

  logic        mck = 1'b0;
  logic        reset_n;
  logic [15:0] s_left, s_right;
  logic        s_valid;
  logic        s_ready0, bck0, lrck0, data0, underrun0;
  logic        s_ready1, bck1, lrck1, data1, underrun1;

  always #5 mck = ~mck;

  i2s_tx_serializer #(.MCK_PER_BCK(M), .FORMAT(0)) dut_i2s (
    .mck(mck), .reset_n(reset_n), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready0), .bck(bck0), .lrck(lrck0),
    .data(data0), .underrun(underrun0));

  i2s_tx_serializer #(.MCK_PER_BCK(M), .FORMAT(1)) dut_lj (
    .mck(mck), .reset_n(reset_n), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready1), .bck(bck1), .lrck(lrck1),
    .data(data1), .underrun(underrun1));

  int n_checks = 0;
  int n_fail   = 0;
  int under_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edge count since release gives the position in the frame; a
  // queue of accepted pairs decides what each frame carries.
  int          model_n = 0;
  logic [31:0] pend_q[$];
  logic [15:0] cur_l = '0, cur_r = '0;
  logic        exp_bck, exp_lrck0, exp_lrck1, exp_data0, exp_data1, exp_under, exp_ready;
  int          exp_bit = 0;
  int          m_p, m_sb;
  logic        m_acc, m_right;
  logic [15:0] m_word;
  logic        cap0[64];
  logic        cap1[64];

  function automatic logic slot_bit(input logic [15:0] w, input int pos);
    if (pos < 0 || pos > 15) return 1'b0;
    return w[15 - pos];
  endfunction

  always @(posedge mck) begin
    if (!reset_n) begin
      model_n = 0;
      pend_q.delete();
      cur_l = '0;
      cur_r = '0;
    end else begin
      m_acc = s_valid && (pend_q.size() == 0);
      model_n++;
      m_p = model_n - 1;
      exp_under = 1'b0;
      if ((m_p % FRAME) == 0) begin
        if (pend_q.size() > 0) begin
          {cur_l, cur_r} = pend_q.pop_front();
        end else begin
          cur_l = '0;
          cur_r = '0;
          exp_under = 1'b1;
        end
      end
      if (m_acc) pend_q.push_back({s_left, s_right});
      exp_ready = (pend_q.size() == 0);
      exp_bck   = (m_p % M) >= (M / 2);
      exp_bit   = (m_p / M) % 64;
      m_right   = exp_bit >= 32;
      m_sb      = exp_bit % 32;
      m_word    = m_right ? cur_r : cur_l;
      exp_lrck0 = m_right;
      exp_lrck1 = !m_right;
      exp_data0 = slot_bit(m_word, m_sb - 1);
      exp_data1 = slot_bit(m_word, m_sb);
    end
  end

  always @(negedge mck) begin
    if (!reset_n || model_n == 0) begin
      chk("rst.bck",      bck0,      1'b1);
      chk("rst.lrck_i2s", lrck0,     1'b1);
      chk("rst.lrck_lj",  lrck1,     1'b0);
      chk("rst.data",     data0 | data1, 1'b0);
      chk("rst.underrun", underrun0 | underrun1, 1'b0);
      chk("rst.s_ready",  s_ready0 & s_ready1, 1'b1);
    end else begin
      chk("i2s.bck",      bck0,      exp_bck);
      chk("lj.bck",       bck1,      exp_bck);
      chk("i2s.lrck",     lrck0,     exp_lrck0);
      chk("lj.lrck",      lrck1,     exp_lrck1);
      chk("i2s.data",     data0,     exp_data0);
      chk("lj.data",      data1,     exp_data1);
      chk("i2s.underrun", underrun0, exp_under);
      chk("lj.underrun",  underrun1, exp_under);
      chk("i2s.s_ready",  s_ready0,  exp_ready);
      chk("lj.s_ready",   s_ready1,  exp_ready);
      cap0[exp_bit] = data0;
      cap1[exp_bit] = data1;
    end
    if (underrun0) under_cnt++;
  end

  task automatic wait_n(input int target);
    int budget = 0;
    while (model_n != target && budget < 4000) begin
      @(negedge mck);
      budget++;
    end
    chk("wait_n.reached", model_n, target);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    logic rdy;
    int   k;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    for (k = 0; k < 600; k++) begin
      rdy = s_ready0;
      @(negedge mck);
      if (rdy) break;
    end
    s_valid = 1'b0;
    chk("send.accepted", (k < 600), 1'b1);
  endtask

  task automatic check_words(input string name, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] w0l, w0r, w1l, w1r;
    for (int i = 0; i < 16; i++) begin
      w0l[15 - i] = cap0[1 + i];
      w0r[15 - i] = cap0[33 + i];
      w1l[15 - i] = cap1[i];
      w1r[15 - i] = cap1[32 + i];
    end
    chk({name, ".i2s_left"},  w0l, l);
    chk({name, ".i2s_right"}, w0r, r);
    chk({name, ".lj_left"},   w1l, l);
    chk({name, ".lj_right"},  w1r, r);
  endtask

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    repeat (3) @(negedge mck);
    chk("lit.rst_bck",  bck0,  1'b1);
    chk("lit.rst_lrck", lrck0, 1'b1);
    reset_n = 1'b1;
    @(negedge mck);
    chk("lit.first_bck_fall", bck0,      1'b0);
    chk("lit.first_lrck_i2s", lrck0,     1'b0);
    chk("lit.first_lrck_lj",  lrck1,     1'b1);
    chk("lit.first_underrun", underrun0, 1'b1);

    // Normal frame in both formats.
    send(16'hA5C3, 16'h0001);
    wait_n(2 * FRAME);
    check_words("lit.a5c3", 16'hA5C3, 16'h0001);
    chk("lit.under_cnt1", under_cnt, 1);

    // Three starved frames, then a pair sent mid-frame.
    wait_n(5 * FRAME);
    check_words("lit.muted", 16'h0000, 16'h0000);
    chk("lit.under_cnt4", under_cnt, 4);
    wait_n(5 * FRAME + 8);
    send(16'h8000, 16'h7FFF);
    wait_n(7 * FRAME);
    check_words("lit.8000", 16'h8000, 16'h7FFF);
    chk("lit.under_cnt5", under_cnt, 5);

    // Handshake landing exactly on the load edge.
    send(16'h1234, 16'hFEDC);
    chk("lit.bnd_underrun", underrun0, 1'b1);
    chk("lit.bnd_ready_lo", s_ready0,  1'b0);
    wait_n(8 * FRAME);
    chk("lit.bnd_ready_still_lo", s_ready0, 1'b0);
    wait_n(8 * FRAME + 1);
    chk("lit.bnd_ready_hi", s_ready0, 1'b1);
    wait_n(9 * FRAME);
    check_words("lit.1234", 16'h1234, 16'hFEDC);
    chk("lit.under_cnt6", under_cnt, 6);

    // Asynchronous reset mid-frame with holding full.
    send(16'hCAFE, 16'hBEEF);
    wait_n(9 * FRAME + 20 * M + 2);
    chk("lit.pre_rst_ready", s_ready0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("lit.async_bck",      bck0,      1'b1);
    chk("lit.async_lrck_i2s", lrck0,     1'b1);
    chk("lit.async_lrck_lj",  lrck1,     1'b0);
    chk("lit.async_data",     data0,     1'b0);
    chk("lit.async_ready",    s_ready0,  1'b1);
    chk("lit.async_underrun", underrun0, 1'b0);
    chk("lit.under_cnt7", under_cnt, 7);
    repeat (2) @(negedge mck);
    reset_n = 1'b1;
    @(negedge mck);
    chk("lit.post_rst_underrun", underrun0, 1'b1);
    wait_n(FRAME);
    check_words("lit.post_rst_f0", 16'h0000, 16'h0000);
    chk("lit.under_cnt8", under_cnt, 8);
    wait_n(2 * FRAME);
    check_words("lit.post_rst_f1", 16'h0000, 16'h0000);
    chk("lit.under_cnt9", under_cnt, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Transmit-side serializer: accepts parallel 16-bit stereo PCM samples over a valid/ready handshake and generates BCK/LRCK/DATA, master-clocked from `mck`. Output format is standard I2S or 16-bit left-justified (16LJ, as driven into the 701ES/501ES DAC path). Used as a local pattern/playback source and as the stimulus end for the I2S-to-16LJ converters.

## Interface
- `MCK_PER_BCK`, 4: mck cycles per BCK period; even, ≥2. 4 gives mck = 256fs with BCK = 64fs.
- `FORMAT`, 0: 0 = I2S, 1 = 16LJ.
- `mck` in 1: sole clock. All logic is on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `s_left` in 16: left sample, two's complement.
- `s_right` in 16: right sample.
- `s_valid` in 1: sample pair present.
- `s_ready` out 1: holding register empty. Combinational: `s_ready = !hold_full`.
- `bck` out 1: bit clock, registered.
- `lrck` out 1: word clock, registered.
- `data` out 1: serial data, registered, MSB first.
- `underrun` out 1: one-mck pulse at a frame start that finds no sample.

## Operation
- **Counters**
  - `div` counts 0..MCK_PER_BCK-1.
  - `bit` counts 0..63 and advances when `div` wraps.
  - Both reset so that the first mck edge after reset release wraps to `div=0, bit=0`.
- **Registered outputs**: each edge updates outputs from the next-state counters.
  - `bck` = (next `div` ≥ MCK_PER_BCK/2). BCK therefore falls on the same edge that `bit` changes, and `lrck`/`data` change only on BCK falling edges.
- **Frame layout**: 64 BCK per frame, slot 0 = bits 0..31, slot 1 = bits 32..63.
  - I2S:
    - `lrck` = 0 for bits 0..31 (left) and 1 for bits 32..63.
    - Left MSB..LSB on bits 1..16; right on bits 33..48.
  - 16LJ:
    - `lrck` = 1 for bits 0..31 (left) and 0 for bits 32..63.
    - Left on bits 0..15; right on bits 32..47.
  - `data` = 0 on all other bits.
- **Handshake**
  - Transfer occurs on an edge with `s_valid && s_ready`.
  - The pair is stored in the holding register, and `hold_full` is set.
  - `s_left`/`s_right` must be stable while `s_valid` is high and `s_ready` is low.
- **Frame load**: on the edge where `bit` goes 63→0, plus the first edge after reset:
  - If `hold_full`: copy holding into the left/right shift registers and clear `hold_full`. `s_ready` rises the following cycle.
  - If empty: load zeros, transmit a muted frame, and pulse `underrun` for exactly that one cycle.
- **Simultaneous events**: a handshake on the load edge with the holding register empty is an underrun. The accepted pair goes to holding and is transmitted in the next frame.
- **Arithmetic**: shift registers are 16 bits with no sign extension. Slot bits outside the 16 data bits are forced to 0.
- **Reset mid-frame**:
  - All state returns to reset values immediately (asynchronously) and the holding contents are discarded.
  - The next frame starts at bit 0 on the first edge after release.

## Timing
- **Reset values**:
  - `bck` = 1.
  - `lrck` = 1 for I2S, 0 for 16LJ (the right-slot level, so the first left edge is visible).
  - `data` = 0, `underrun` = 0, `s_ready` = 1.
- **Frame length**: 64·MCK_PER_BCK mck cycles, which is 256 at the default.
- **BCK duty**: exactly 50%.
- **Latency**: from a handshake accepted before a frame boundary to the left MSB on `data`:
  - 16LJ: the next 63→0 edge.
  - I2S: that edge plus MCK_PER_BCK cycles.
- **Throughput**: one pair per frame. `s_ready` is low for at most one frame plus one cycle while the source keeps pace.

## Structure
- **Shared package (`i2s_pkg`)**:
  - `FMT_I2S` and `FMT_LJ16` constants.
  - `SLOT_BITS` = 32, `FRAME_BITS` = 64, `SAMPLE_BITS` = 16.
  - LRCK level constants per format.
- **Sub-module `i2s_frame_timer`**: owns `div`/`bit` and outputs next-`bit`, `bck_next`, and a `frame_start` strobe. The serializer holds the handshake, holding register, shift registers and data/lrck mux.

## Test plan
1. **Reset**: hold `reset_n`=0 → `bck`=1, `lrck`=1 (I2S), `data`=0, `s_ready`=1. Release → `bck` falls on the first edge and `lrck` goes 0.
2. **I2S frame**: FORMAT=0, send L=16'hA5C3, R=16'h0001 before the first boundary → LRCK low bits 1..16 carry A5C3 MSB-first, bits 33..48 carry 0001, all other bits 0, `underrun` never pulses.
3. **16LJ frame**: FORMAT=1, same pair → A5C3 on bits 0..15 with `lrck`=1, 0001 on bits 32..47 with `lrck`=0.
4. **Underrun**: no `s_valid` for 3 frames → `underrun` pulses once per frame at `bit`=0, `data` stays 0. Then send 16'h8000/16'h7FFF → correct frame follows with no pulse.
5. **Boundary handshake**: `s_valid` asserted exactly on the load edge with holding empty → `underrun` pulses, the pair appears in the next frame, `s_ready` is low until that frame's load.
6. **Async reset**: assert `reset_n` at bit 20 of a frame with holding full → outputs return to reset values without waiting for an mck edge, the held pair is never transmitted, `underrun` pulses at the first post-reset frame.
